// File: rtl/shift_sched.sv
// Round-robin arbiter and sequencer for a shared WIDTH-bit load/shift datapath.
// One granted requester gets a one-cycle load followed by exactly WIDTH shift cycles.
module shift_sched #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREQ  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*WIDTH-1:0]        req_data,
    input  logic                         abort,
    output logic [NREQ-1:0]              gnt,
    output logic                         busy,
    output logic                         sh_load,
    output logic                         sh_en,
    output logic [WIDTH-1:0]             sh_data,
    output logic [NREQ-1:0]              done,
    output logic [$clog2(WIDTH+1)-1:0]   shift_cnt
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   idx_hi;
    logic [IW-1:0]   idx_lo;
    logic            found_hi;
    logic            found_lo;
    logic [WIDTH-1:0] sel_data;

    // Rotating priority: first requester above last wins, otherwise wrap to the lowest one.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found_hi && (IW'(i) > last) && req[i]) begin
                found_hi = 1'b1;
                idx_hi   = IW'(i);
            end
            if (!found_lo && (IW'(i) <= last) && req[i]) begin
                found_lo = 1'b1;
                idx_lo   = IW'(i);
            end
        end
        pick_idx = found_hi ? idx_hi : idx_lo;
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IW'(i) == pick_idx) sel_data = req_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            sh_load   <= 1'b0;
            sh_en     <= 1'b0;
            sh_data   <= '0;
            done      <= '0;
            shift_cnt <= '0;
            last      <= IW'(NREQ - 1);
        end else begin
            done <= '0;
            unique case (state)
                IDLE: begin
                    if (req != '0) begin
                        sh_data <= sel_data;
                        gnt     <= NREQ'(1) << pick_idx;
                        last    <= pick_idx;
                        busy    <= 1'b1;
                        sh_load <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    sh_load <= 1'b0;
                    if (abort) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        busy      <= 1'b0;
                        shift_cnt <= '0;
                    end else begin
                        state     <= SHIFT;
                        sh_en     <= 1'b1;
                        shift_cnt <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        busy      <= 1'b0;
                        sh_en     <= 1'b0;
                        shift_cnt <= '0;
                    end else if (shift_cnt == CW'(1)) begin
                        state      <= DONE;
                        gnt        <= '0;
                        busy       <= 1'b0;
                        sh_en      <= 1'b0;
                        shift_cnt  <= '0;
                        done[last] <= 1'b1;
                    end else begin
                        shift_cnt <= shift_cnt - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched: directed scenarios plus randomized
// transactions scored against a transaction-level round-robin model.
module tb_shift_sched;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned NREQ  = 2;
    localparam int unsigned CW    = $clog2(WIDTH + 1);
    localparam int unsigned DW    = NREQ * WIDTH;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [DW-1:0]     req_data = '0;
    logic              abort = 1'b0;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              sh_load;
    logic              sh_en;
    logic [WIDTH-1:0]  sh_data;
    logic [NREQ-1:0]   done;
    logic [CW-1:0]     shift_cnt;

    int tests_run = 0;
    int failures  = 0;
    int cycle     = 0;
    int mlast     = NREQ - 1;

    shift_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .abort     (abort),
        .gnt       (gnt),
        .busy      (busy),
        .sh_load   (sh_load),
        .sh_en     (sh_en),
        .sh_data   (sh_data),
        .done      (done),
        .shift_cnt (shift_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // Reference: winner is the first asserted request after the previous winner, modulo NREQ.
    function automatic int model_pick(input logic [NREQ-1:0] r, input int prev);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(prev + k) % NREQ]) return (prev + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] slice_of(input logic [DW-1:0] d, input int i);
        logic [DW-1:0] t;
        t = d >> (i * WIDTH);
        return t[WIDTH-1:0];
    endfunction

    task automatic do_reset();
        rst   = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        mlast = NREQ - 1;
    endtask

    // Records one transaction from its first granted cycle until outputs return to idle.
    task automatic observe(input int abort_at, input bit scramble,
                           output int gidx, output logic [NREQ-1:0] gval,
                           output logic [WIDTH-1:0] dload, output logic [WIDTH-1:0] dend,
                           output int gstamp, output int loads, output int ens,
                           output int cnt_bad, output int dones,
                           output logic [NREQ-1:0] dval, output int total, output int bad);
        int budget;
        int idx;
        gidx = -1; gval = '0; dload = '0; dend = '0; gstamp = -1;
        loads = 0; ens = 0; cnt_bad = 0; dones = 0; dval = '0; total = 0; bad = 0;
        budget = 0;
        while (gnt == '0 && budget < 40) begin
            @(posedge clk); #1;
            budget++;
        end
        if (gnt == '0) return;
        gstamp = cycle;
        gval   = gnt;
        dload  = sh_data;
        for (int k = 0; k < NREQ; k++) if (gnt[k]) gidx = k;
        idx = 0;
        while (idx < 40) begin
            abort = 1'b0;
            if (gnt == '0 && !busy && done == '0 && !sh_load && !sh_en) break;
            total++;
            if (sh_load) loads++;
            if (sh_en) begin
                if (shift_cnt !== CW'(WIDTH - ens)) cnt_bad++;
                ens++;
            end
            if (done != '0) begin
                dones++;
                dval = done;
                dend = sh_data;
            end
            if ($countones(gnt) > 1 || (done != '0 && busy)) bad++;
            if (idx == 1 && scramble) begin
                req      = '0;
                req_data = DW'($urandom);
            end
            if (idx == abort_at) abort = 1'b1;
            idx++;
            @(posedge clk); #1;
        end
        if (idx >= 40) gidx = -1;
    endtask

    task automatic test_reset();
        int gidx, gstamp, loads, ens, cnt_bad, dones, total, bad, rel;
        logic [NREQ-1:0] gval, dval;
        logic [WIDTH-1:0] dload, dend;
        rst = 1'b0;
        req = 2'b11;
        req_data = DW'($urandom);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({gnt, busy, sh_load, sh_en, sh_data, done, shift_cnt} !== '0) begin
                failures++;
                $display("FAIL reset_outputs: got gnt=%b busy=%b load=%b en=%b data=%b done=%b cnt=%0d, expected all 0",
                         gnt, busy, sh_load, sh_en, sh_data, done, shift_cnt);
            end
        end
        rst = 1'b1;
        rel = cycle;
        observe(-1, 0, gidx, gval, dload, dend, gstamp, loads, ens, cnt_bad, dones, dval, total, bad);
        tests_run++;
        if (gidx !== 0 || gstamp !== rel + 1) begin
            failures++;
            $display("FAIL reset_first_grant: got idx=%0d at cycle %0d, expected idx=0 at cycle %0d", gidx, gstamp, rel + 1);
        end
        req = '0;
    endtask

    task automatic test_single();
        int gidx, gstamp, loads, ens, cnt_bad, dones, total, bad;
        logic [NREQ-1:0] gval, dval;
        logic [WIDTH-1:0] dload, dend;
        do_reset();
        req = 2'b01;
        req_data = DW'($urandom);
        req_data[3:0] = 4'b1101;
        observe(-1, 0, gidx, gval, dload, dend, gstamp, loads, ens, cnt_bad, dones, dval, total, bad);
        req = '0;
        mlast = 0;
        tests_run++;
        if (gval !== 2'b01 || dload !== 4'b1101) begin
            failures++;
            $display("FAIL single_grant: got gnt=%b data=%b, expected gnt=01 data=1101", gval, dload);
        end
        tests_run++;
        if (loads !== 1 || ens !== WIDTH || cnt_bad !== 0) begin
            failures++;
            $display("FAIL single_phases: got load=%0d en=%0d cnt_err=%0d, expected load=1 en=%0d cnt_err=0", loads, ens, cnt_bad, WIDTH);
        end
        tests_run++;
        if (dones !== 1 || dval !== 2'b01 || total !== 6 || bad !== 0) begin
            failures++;
            $display("FAIL single_done: got done_cycles=%0d done=%b total=%0d viol=%0d, expected 1 01 6 0", dones, dval, total, bad);
        end
    endtask

    task automatic test_contention();
        int gidx, gstamp, loads, ens, cnt_bad, dones, total, bad, w, prev_stamp;
        logic [NREQ-1:0] gval, dval;
        logic [WIDTH-1:0] dload, dend;
        do_reset();
        req = 2'b11;
        req_data = {4'b0110, 4'b1101};
        prev_stamp = -1;
        for (int t = 0; t < 3; t++) begin
            w = model_pick(req, mlast);
            mlast = w;
            observe(-1, 0, gidx, gval, dload, dend, gstamp, loads, ens, cnt_bad, dones, dval, total, bad);
            tests_run++;
            if (gidx !== w || dload !== slice_of(req_data, w)) begin
                failures++;
                $display("FAIL contention_grant%0d: got idx=%0d data=%b, expected idx=%0d data=%b", t, gidx, dload, w, slice_of(req_data, w));
            end
            if (t > 0) begin
                tests_run++;
                if (gstamp - prev_stamp !== WIDTH + 3) begin
                    failures++;
                    $display("FAIL contention_period%0d: got %0d cycles, expected %0d", t, gstamp - prev_stamp, WIDTH + 3);
                end
            end
            prev_stamp = gstamp;
        end
        req = '0;
    endtask

    task automatic test_abort();
        int gidx, gstamp, loads, ens, cnt_bad, dones, total, bad;
        logic [NREQ-1:0] gval, dval;
        logic [WIDTH-1:0] dload, dend;
        do_reset();
        req = 2'b11;
        req_data = DW'($urandom);
        observe(2, 0, gidx, gval, dload, dend, gstamp, loads, ens, cnt_bad, dones, dval, total, bad);
        tests_run++;
        if (gidx !== 0 || ens !== 2 || dones !== 0 || total !== 3) begin
            failures++;
            $display("FAIL abort_cut: got idx=%0d en=%0d done_cycles=%0d total=%0d, expected 0 2 0 3", gidx, ens, dones, total);
        end
        mlast = 0;
        observe(-1, 0, gidx, gval, dload, dend, gstamp, loads, ens, cnt_bad, dones, dval, total, bad);
        req = '0;
        tests_run++;
        if (gidx !== model_pick(2'b11, mlast) || ens !== WIDTH || dones !== 1) begin
            failures++;
            $display("FAIL abort_next: got idx=%0d en=%0d done_cycles=%0d, expected %0d %0d 1", gidx, ens, dones, model_pick(2'b11, mlast), WIDTH);
        end
        mlast = 1;
    endtask

    task automatic test_mid_reset();
        int gidx, gstamp, loads, ens, cnt_bad, dones, total, bad, budget;
        logic [NREQ-1:0] gval, dval;
        logic [WIDTH-1:0] dload, dend;
        do_reset();
        req = 2'b01;
        req_data = {4'b0011, 4'b1010};
        budget = 0;
        while (!sh_en && budget < 40) begin
            @(posedge clk); #1;
            budget++;
        end
        tests_run++;
        if (!sh_en) begin
            failures++;
            $display("FAIL midreset_reach_shift: got sh_en=0 after %0d cycles, expected 1", budget);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({gnt, busy, sh_load, sh_en, sh_data, done, shift_cnt} !== '0) begin
            failures++;
            $display("FAIL midreset_async: got gnt=%b busy=%b load=%b en=%b data=%b done=%b cnt=%0d, expected all 0",
                     gnt, busy, sh_load, sh_en, sh_data, done, shift_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        observe(-1, 0, gidx, gval, dload, dend, gstamp, loads, ens, cnt_bad, dones, dval, total, bad);
        req = '0;
        mlast = 0;
        tests_run++;
        if (gidx !== 0 || dload !== 4'b1010 || total !== 6 || ens !== WIDTH || dones !== 1 || cnt_bad !== 0) begin
            failures++;
            $display("FAIL midreset_recover: got idx=%0d data=%b total=%0d en=%0d done_cycles=%0d cnt_err=%0d, expected 0 1010 6 %0d 1 0",
                     gidx, dload, total, ens, dones, cnt_bad, WIDTH);
        end
    endtask

    task automatic test_held_inputs();
        int gidx, gstamp, loads, ens, cnt_bad, dones, total, bad;
        logic [NREQ-1:0] gval, dval;
        logic [WIDTH-1:0] dload, dend;
        do_reset();
        req = 2'b10;
        req_data = {4'b1011, 4'b0000};
        observe(-1, 1, gidx, gval, dload, dend, gstamp, loads, ens, cnt_bad, dones, dval, total, bad);
        mlast = 1;
        tests_run++;
        if (gidx !== 1 || dload !== 4'b1011 || dend !== 4'b1011) begin
            failures++;
            $display("FAIL held_data: got idx=%0d load_data=%b end_data=%b, expected 1 1011 1011", gidx, dload, dend);
        end
        tests_run++;
        if (ens !== WIDTH || dones !== 1 || dval !== 2'b10) begin
            failures++;
            $display("FAIL held_done: got en=%0d done_cycles=%0d done=%b, expected %0d 1 10", ens, dones, dval, WIDTH);
        end
    endtask

    task automatic test_random();
        int gidx, gstamp, loads, ens, cnt_bad, dones, total, bad, w, abort_at;
        int exp_ens, exp_dones, exp_total;
        bit scramble, aborted;
        logic [NREQ-1:0] gval, dval, r, exp_done;
        logic [WIDTH-1:0] dload, dend, exp_data;
        do_reset();
        for (int it = 0; it < 25; it++) begin
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req = r;
            req_data = DW'($urandom);
            abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WIDTH + 1)) : -1;
            scramble = 1'($urandom_range(0, 1));
            w = model_pick(r, mlast);
            mlast = w;
            exp_data = slice_of(req_data, w);
            aborted = (abort_at >= 0) && (abort_at <= WIDTH);
            exp_ens = aborted ? abort_at : WIDTH;
            exp_dones = aborted ? 0 : 1;
            exp_total = aborted ? abort_at + 1 : WIDTH + 2;
            exp_done = aborted ? '0 : (NREQ'(1) << w);
            observe(abort_at, scramble, gidx, gval, dload, dend, gstamp, loads, ens, cnt_bad, dones, dval, total, bad);
            tests_run++;
            if (gidx !== w || dload !== exp_data || ens !== exp_ens || dones !== exp_dones ||
                dval !== exp_done || total !== exp_total || cnt_bad !== 0 || bad !== 0) begin
                failures++;
                $display("FAIL random%0d: got idx=%0d data=%b en=%0d dc=%0d done=%b total=%0d cerr=%0d viol=%0d, expected idx=%0d data=%b en=%0d dc=%0d done=%b total=%0d 0 0",
                         it, gidx, dload, ens, dones, dval, total, cnt_bad, bad,
                         w, exp_data, exp_ens, exp_dones, exp_done, exp_total);
            end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_abort();
        test_mid_reset();
        test_held_inputs();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/shift_sched.md
# shift_sched

Round-robin controller that shares one WIDTH-bit load/shift datapath among NREQ requesters. It grants one requester at a time and drives the datapath's load and data lines for one cycle, then shift-enable for exactly WIDTH cycles. It then pulses a per-requester done and returns to idle. The block sits between the requesting FSMs and the shift register and contains no shift storage itself.

## Interface
- WIDTH, 4, shift register width and shift count per transaction (2..16)
- NREQ, 2, number of requesters (2..4)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  request, one bit per requester; level, held until done
- req_data  in  NREQ*WIDTH  load word; requester i occupies bits [i*WIDTH +: WIDTH]
- abort  in  1  synchronous cancel of the current transaction
- gnt  out  NREQ  one-hot grant, held LOAD through SHIFT
- busy  out  1  high in LOAD and SHIFT
- sh_load  out  1  datapath load strobe
- sh_en  out  1  datapath shift enable
- sh_data  out  WIDTH  word presented to the datapath; valid while sh_load=1
- done  out  NREQ  one-cycle completion pulse to the granted requester
- shift_cnt  out  clog2(WIDTH+1)  shifts remaining

## Operation
- All outputs are registered. Reset (rst=0, asynchronous) forces:
  - state=IDLE
  - gnt=0, busy=0, sh_load=0, sh_en=0, sh_data=0, done=0, shift_cnt=0
  - round-robin pointer last=NREQ-1, so requester 0 has highest priority first
- States: IDLE, LOAD, SHIFT, DONE.
- **IDLE:** If req!=0, pick the first asserted bit searching upward from last+1 (mod NREQ). Then:
  - capture its req_data slice into sh_data
  - set gnt to that bit and last to that index
  - go to LOAD
  - If req=0, stay in IDLE.
- **LOAD:** sh_load=1, busy=1, one cycle. Next state is SHIFT with shift_cnt=WIDTH.
- **SHIFT:** sh_en=1, busy=1. shift_cnt decrements each edge. Leave for DONE when shift_cnt reaches 1, giving exactly WIDTH cycles of sh_en.
- **DONE:** gnt=0, busy=0, done[last]=1 for one cycle. Next state is IDLE.
- **abort** sampled high in LOAD or SHIFT:
  - next state IDLE
  - gnt, sh_load, sh_en and shift_cnt cleared
  - no done pulse
  - last keeps the aborted index, so fairness still advances
  - abort in IDLE or DONE is ignored.
- req deasserting mid-transaction does not shorten it; the transaction completes and done still pulses.
- req_data changes after the grant edge do not affect sh_data.
- sh_data holds its last value outside LOAD.
- gnt is never asserted in more than one bit. done is never asserted outside DONE.

## Timing
- Request sampled high at edge E0 in IDLE:
  - LOAD occupies E0..E1 (gnt and sh_load high)
  - SHIFT occupies E1..E1+WIDTH
  - DONE occupies the next cycle
  - back in IDLE one cycle later
- Grant-to-done latency is WIDTH+1 cycles. The full transaction period is WIDTH+3 cycles including the IDLE arbitration cycle.
- With continuous requests from all requesters, grants rotate 0,1,..,NREQ-1,0. Each requester waits at most (NREQ-1)*(WIDTH+3) cycles.
- A request arriving during DONE is arbitrated in the following IDLE cycle.
- Reset asserted mid-SHIFT:
  - all outputs go to their reset values immediately, without waiting for a clock edge
  - no done pulse
  - operation resumes from IDLE on the first edge after rst=1

## Test plan
- **Reset values:** hold rst=0 for 2 cycles with req=2'b11. Required: all outputs 0, and no grant until rst=1.
- **Single transaction (WIDTH=4):** req=01, req_data[3:0]=4'b1101.
  - gnt=01 and sh_load=1 with sh_data=1101 for exactly 1 cycle
  - sh_en=1 for exactly 4 cycles while shift_cnt steps 4,3,2,1
  - done=01 for 1 cycle
  - total 6 cycles from grant to IDLE
- **Contention:** req=11 held continuously, with data 1101 for requester 0 and 0110 for requester 1. Required:
  - grants alternate 0,1,0 on a 7-cycle period
  - sh_data alternates 1101, 0110
- **abort:** assert abort in the 2nd SHIFT cycle with req=11. Required:
  - sh_en drops on the next edge, with no done pulse
  - the next grant goes to requester 1
- **Mid-operation reset:** drive rst low during SHIFT. Required:
  - all outputs 0 asynchronously
  - after release with req=01, a clean 6-cycle transaction
- **Held inputs:** drop req and change req_data during SHIFT. Required:
  - the transaction completes with its original data
  - done still pulses
